// File: rtl/segasys1_sound_cmd_if.sv
// Sound-command interface: main CPU command bytes -> FIFO -> sound CPU latch.
// Raises an NMI per queued command and generates the periodic sound IRQ.
module segasys1_sound_cmd_if #(
  parameter int          FIFO_AW    = 2,
  parameter logic [3:0]  LATCH_A    = 4'hE,
  parameter int          NMI_LEN    = 8,
  parameter logic [15:0] IRQ_PERIOD = 16'd16384,
  parameter logic [7:0]  IRQ_HOLD   = 8'd64
) (
  input  logic        CLK48M,
  input  logic        RESET_N,
  input  logic        CLK_EN,
  input  logic        SNDRQ,
  input  logic [7:0]  SNDNO,
  input  logic [15:0] SCPUAD,
  input  logic        SCPU_MREQ,
  input  logic        SCPU_RD,
  input  logic        SCPU_M1,
  input  logic        SCPU_IORQ,
  output logic        SCPU_CS_LATCH,
  output logic [7:0]  SCPU_LATCH_DO,
  output logic        SCPU_NMI,
  output logic        SCPU_INT,
  output logic        PENDING,
  output logic        OVERRUN
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int NMI_CW = $clog2(NMI_LEN + 1);

  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO   = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [NMI_CW-1:0]  NMI_ONE    = NMI_CW'(1);
  localparam logic [NMI_CW-1:0]  NMI_ZERO   = NMI_CW'(0);
  localparam logic [NMI_CW-1:0]  NMI_TARGET = NMI_CW'(NMI_LEN);

  typedef enum logic [1:0] {
    NMI_IDLE   = 2'd0,
    NMI_ASSERT = 2'd1,
    NMI_WAIT   = 2'd2
  } nmi_state_t;

  // FIFO and edge-detect state
  logic               sndrq_prev_r;
  logic               cs_prev_r;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [7:0]         latch_do_r;
  logic               pending_r;
  logic               overrun_r;

  logic               cs_s;
  logic               push_req_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic [FIFO_AW:0]   count_next_s;

  // NMI state
  nmi_state_t         nmi_state_r;
  nmi_state_t         nmi_state_s;
  logic [NMI_CW-1:0]  nmi_tick_r;
  logic [NMI_CW-1:0]  nmi_tick_s;
  logic [NMI_CW-1:0]  nmi_tick_inc_s;
  logic               nmi_pop_r;
  logic               nmi_pop_s;
  logic               nmi_r;
  logic               nmi_s;

  // Periodic IRQ state
  logic [15:0]        irq_cnt_r;
  logic [7:0]         irq_hold_r;
  logic [7:0]         irq_hold_inc_s;
  logic               int_r;
  logic               wrap_s;
  logic               ack_s;

  assign cs_s          = (SCPUAD[15:12] == LATCH_A) & SCPU_MREQ & SCPU_RD;
  assign SCPU_CS_LATCH = cs_s;
  assign SCPU_LATCH_DO = latch_do_r;
  assign SCPU_NMI      = nmi_r;
  assign SCPU_INT      = int_r;
  assign PENDING       = pending_r;
  assign OVERRUN       = overrun_r;

  // Push/pop decode; a pop frees a slot so a simultaneous push is accepted when full
  always_comb begin
    push_req_s   = SNDRQ & ~sndrq_prev_r;
    pop_s        = cs_prev_r & ~cs_s & (count_r != CNT_ZERO);
    push_s       = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    if (push_req_s & ((count_r != CNT_FULL) | pop_s)) begin
      push_s = 1'b1;
    end else begin
      drop_s = push_req_s;
    end
    if (push_s & ~pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s & ~push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Previous-value registers for the strobe and latch-select edge detectors
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      sndrq_prev_r <= 1'b0;
      cs_prev_r    <= 1'b0;
    end else begin
      sndrq_prev_r <= SNDRQ;
      cs_prev_r    <= cs_s;
    end
  end

  // FIFO storage; the pushed byte lands at the tail slot
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= SNDNO;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r  <= {FIFO_AW{1'b0}};
      rd_ptr_r  <= {FIFO_AW{1'b0}};
      count_r   <= CNT_ZERO;
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      wr_ptr_r  <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r  <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r   <= count_next_s;
      pending_r <= (count_next_s != CNT_ZERO);
      overrun_r <= overrun_r | drop_s;
    end
  end

  // Output latch follows the head one cycle later and holds when the FIFO drains
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      latch_do_r <= 8'h00;
    end else if (count_r != CNT_ZERO) begin
      latch_do_r <= mem_r[rd_ptr_r];
    end else begin
      latch_do_r <= latch_do_r;
    end
  end

  // NMI sequencing: fixed-length pulse, then wait for the command to be read
  always_comb begin
    nmi_state_s    = nmi_state_r;
    nmi_tick_s     = nmi_tick_r;
    nmi_pop_s      = nmi_pop_r;
    nmi_s          = nmi_r;
    nmi_tick_inc_s = nmi_tick_r + NMI_ONE;
    case (nmi_state_r)
      NMI_IDLE: begin
        if (pending_r) begin
          nmi_state_s = NMI_ASSERT;
          nmi_s       = 1'b1;
          nmi_tick_s  = NMI_ZERO;
          nmi_pop_s   = 1'b0;
        end else begin
          nmi_s = 1'b0;
        end
      end
      NMI_ASSERT: begin
        nmi_pop_s = nmi_pop_r | pop_s;
        if (CLK_EN) begin
          nmi_tick_s = nmi_tick_inc_s;
          if (nmi_tick_inc_s == NMI_TARGET) begin
            nmi_s       = 1'b0;
            nmi_state_s = (nmi_pop_r | pop_s) ? NMI_IDLE : NMI_WAIT;
          end else begin
            nmi_s = 1'b1;
          end
        end else begin
          nmi_tick_s = nmi_tick_r;
        end
      end
      NMI_WAIT: begin
        nmi_s = 1'b0;
        if (pop_s) begin
          nmi_state_s = NMI_IDLE;
        end else begin
          nmi_state_s = NMI_WAIT;
        end
      end
      default: begin
        nmi_state_s = NMI_IDLE;
        nmi_s       = 1'b0;
      end
    endcase
  end

  // NMI state register
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      nmi_state_r <= NMI_IDLE;
      nmi_tick_r  <= NMI_ZERO;
      nmi_pop_r   <= 1'b0;
      nmi_r       <= 1'b0;
    end else begin
      nmi_state_r <= nmi_state_s;
      nmi_tick_r  <= nmi_tick_s;
      nmi_pop_r   <= nmi_pop_s;
      nmi_r       <= nmi_s;
    end
  end

  assign wrap_s         = CLK_EN & (irq_cnt_r == (IRQ_PERIOD - 16'd1));
  assign ack_s          = SCPU_M1 & SCPU_IORQ;
  assign irq_hold_inc_s = irq_hold_r + 8'd1;

  // Free-running period counter, one wrap per IRQ_PERIOD ticks
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_cnt_r <= 16'd0;
    end else if (CLK_EN) begin
      irq_cnt_r <= wrap_s ? 16'd0 : (irq_cnt_r + 16'd1);
    end else begin
      irq_cnt_r <= irq_cnt_r;
    end
  end

  // IRQ request: set on wrap, cleared by acknowledge or hold timeout
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      int_r      <= 1'b0;
      irq_hold_r <= 8'd0;
    end else if (wrap_s) begin
      int_r      <= 1'b1;
      irq_hold_r <= 8'd0;
    end else if (int_r) begin
      if (ack_s) begin
        int_r <= 1'b0;
      end else if (CLK_EN) begin
        irq_hold_r <= irq_hold_inc_s;
        int_r      <= (irq_hold_inc_s != IRQ_HOLD);
      end else begin
        int_r <= 1'b1;
      end
    end else begin
      int_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_segasys1_sound_cmd_if.sv
// Bench for segasys1_sound_cmd_if: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_segasys1_sound_cmd_if;

  localparam int FIFO_AW    = 2;
  localparam int DEPTH      = 4;
  localparam int NMI_LEN    = 8;
  localparam int IRQ_PERIOD = 80;
  localparam int IRQ_HOLD   = 64;
  localparam int EN_DIV     = 12;

  logic        CLK48M    = 1'b0;
  logic        RESET_N   = 1'b1;
  logic        CLK_EN    = 1'b0;
  logic        SNDRQ     = 1'b0;
  logic [7:0]  SNDNO     = 8'h00;
  logic [15:0] SCPUAD    = 16'h0000;
  logic        SCPU_MREQ = 1'b0;
  logic        SCPU_RD   = 1'b0;
  logic        SCPU_M1   = 1'b0;
  logic        SCPU_IORQ = 1'b0;
  logic        SCPU_CS_LATCH;
  logic [7:0]  SCPU_LATCH_DO;
  logic        SCPU_NMI;
  logic        SCPU_INT;
  logic        PENDING;
  logic        OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;

  segasys1_sound_cmd_if #(
    .FIFO_AW   (FIFO_AW),
    .LATCH_A   (4'hE),
    .NMI_LEN   (NMI_LEN),
    .IRQ_PERIOD(16'(IRQ_PERIOD)),
    .IRQ_HOLD  (8'(IRQ_HOLD))
  ) dut (
    .CLK48M       (CLK48M),
    .RESET_N      (RESET_N),
    .CLK_EN       (CLK_EN),
    .SNDRQ        (SNDRQ),
    .SNDNO        (SNDNO),
    .SCPUAD       (SCPUAD),
    .SCPU_MREQ    (SCPU_MREQ),
    .SCPU_RD      (SCPU_RD),
    .SCPU_M1      (SCPU_M1),
    .SCPU_IORQ    (SCPU_IORQ),
    .SCPU_CS_LATCH(SCPU_CS_LATCH),
    .SCPU_LATCH_DO(SCPU_LATCH_DO),
    .SCPU_NMI     (SCPU_NMI),
    .SCPU_INT     (SCPU_INT),
    .PENDING      (PENDING),
    .OVERRUN      (OVERRUN)
  );

  always #5 CLK48M = ~CLK48M;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  logic       m_sndrq_prev = 1'b0;
  logic       m_cs_prev    = 1'b0;
  logic       m_pending    = 1'b0;
  logic       m_overrun    = 1'b0;
  logic [7:0] m_latch      = 8'h00;
  logic       m_nmi        = 1'b0;
  logic       m_nmi_pop    = 1'b0;
  int         m_nmi_mode   = 0;   // 0 idle, 1 pulsing, 2 waiting for read
  int         m_nmi_ticks  = 0;
  logic       m_int        = 1'b0;
  int         m_tick_n     = 0;
  int         m_wrap_tick  = 0;
  logic       m_cs, m_push, m_pop, m_ack, m_old_pending;
  logic [7:0] m_dummy;

  initial begin
    forever begin
      @(posedge CLK48M or negedge RESET_N);
      if (!RESET_N) begin
        m_q.delete();
        m_sndrq_prev = 1'b0; m_cs_prev = 1'b0; m_pending = 1'b0; m_overrun = 1'b0;
        m_latch = 8'h00; m_nmi = 1'b0; m_nmi_pop = 1'b0; m_nmi_mode = 0; m_nmi_ticks = 0;
        m_int = 1'b0; m_tick_n = 0; m_wrap_tick = 0;
      end else begin
        m_cs  = (SCPUAD[15:12] == 4'hE) && SCPU_MREQ && SCPU_RD;
        m_push = SNDRQ && !m_sndrq_prev;
        m_pop  = m_cs_prev && !m_cs && (m_q.size() != 0);
        m_ack  = SCPU_M1 && SCPU_IORQ;
        m_old_pending = m_pending;
        // the latch shows the head as it stood before this edge
        if (m_q.size() != 0) m_latch = m_q[0];
        if (m_pop) m_dummy = m_q.pop_front();
        if (m_push) begin
          if (m_q.size() < DEPTH) m_q.push_back(SNDNO);
          else m_overrun = 1'b1;
        end
        m_pending = (m_q.size() != 0);
        m_sndrq_prev = SNDRQ;
        m_cs_prev = m_cs;
        // NMI behaviour
        if (m_nmi_mode == 0) begin
          if (m_old_pending) begin
            m_nmi_mode = 1; m_nmi = 1'b1; m_nmi_ticks = 0; m_nmi_pop = 1'b0;
          end
        end else if (m_nmi_mode == 1) begin
          if (m_pop) m_nmi_pop = 1'b1;
          if (CLK_EN) begin
            m_nmi_ticks++;
            if (m_nmi_ticks == NMI_LEN) begin
              m_nmi = 1'b0;
              m_nmi_mode = m_nmi_pop ? 0 : 2;
            end
          end
        end else begin
          if (m_pop) m_nmi_mode = 0;
        end
        // IRQ: every IRQ_PERIOD-th tick since reset raises it
        if (CLK_EN) m_tick_n++;
        if (CLK_EN && (m_tick_n % IRQ_PERIOD == 0)) begin
          m_int = 1'b1;
          m_wrap_tick = m_tick_n;
        end else if (m_int && (m_ack || (m_tick_n - m_wrap_tick >= IRQ_HOLD))) begin
          m_int = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge CLK48M);
      check("cs_latch", 16'(SCPU_CS_LATCH),
            16'((SCPUAD[15:12] == 4'hE) && SCPU_MREQ && SCPU_RD));
      check("latch_do", 16'(SCPU_LATCH_DO), 16'(m_latch));
      check("pending",  16'(PENDING),  16'(m_pending));
      check("overrun",  16'(OVERRUN),  16'(m_overrun));
      check("nmi",      16'(SCPU_NMI), 16'(m_nmi));
      check("int",      16'(SCPU_INT), 16'(m_int));
    end
  end

  // Clock-enable: one cycle in EN_DIV, changed on the falling edge
  initial begin
    int en_cnt;
    en_cnt = 0;
    forever begin
      @(negedge CLK48M);
      #1;
      en_cnt = (en_cnt + 1) % EN_DIV;
      CLK_EN = (en_cnt == 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    SNDRQ = 1'b1;
    SNDNO = b;
    tick();
    SNDRQ = 1'b0;
    tick();
  endtask

  task automatic read_byte(output logic [7:0] v);
    SCPUAD    = 16'hE000 | 16'($urandom_range(0, 4095));
    SCPU_MREQ = 1'b1;
    SCPU_RD   = 1'b1;
    tick();
    tick();
    v = SCPU_LATCH_DO;
    SCPU_MREQ = 1'b0;
    SCPU_RD   = 1'b0;
    SCPUAD    = 16'h0000;
    tick();
    tick();
  endtask

  logic [7:0] rv;
  int         start_tick;
  int         guard;
  int         cyc;

  initial begin
    #2;
    do_reset();

    // reset state
    check("rst_nmi",     16'(SCPU_NMI),      16'h0);
    check("rst_int",     16'(SCPU_INT),      16'h0);
    check("rst_pending", 16'(PENDING),       16'h0);
    check("rst_overrun", 16'(OVERRUN),       16'h0);
    check("rst_latch",   16'(SCPU_LATCH_DO), 16'h00);

    // single command: latch, NMI length, read, drain
    push_byte(8'h5A);
    check("t1_pending", 16'(PENDING),       16'h1);
    check("t1_latch",   16'(SCPU_LATCH_DO), 16'h5A);
    check("t1_nmi_up",  16'(SCPU_NMI),      16'h1);
    start_tick = m_tick_n;
    guard = 0;
    while (SCPU_NMI && guard < 400) begin
      tick();
      guard++;
    end
    check("t1_nmi_timeout", 16'(guard < 400), 16'h1);
    check("t1_nmi_ticks",   16'(m_tick_n - start_tick), 16'(NMI_LEN));
    read_byte(rv);
    check("t1_read",      16'(rv),      16'h5A);
    check("t1_pending_0", 16'(PENDING), 16'h0);

    // four commands in order
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    for (int i = 1; i <= 4; i++) begin
      read_byte(rv);
      check("t2_read", 16'(rv), 16'(i));
    end
    check("t2_overrun", 16'(OVERRUN), 16'h0);

    // overflow drops the fifth byte and sticks until reset
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("t3_overrun", 16'(OVERRUN), 16'h1);
    for (int i = 0; i < 4; i++) begin
      read_byte(rv);
      check("t3_read", 16'(rv), 16'h10 + 16'(i));
    end
    check("t3_pending_0",  16'(PENDING), 16'h0);
    check("t3_overrun_st", 16'(OVERRUN), 16'h1);
    do_reset();
    check("t3_overrun_clr", 16'(OVERRUN), 16'h0);

    // full FIFO: pop and push on the same edge
    for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
    SCPUAD = 16'hE123; SCPU_MREQ = 1'b1; SCPU_RD = 1'b1;
    tick();
    tick();
    check("t4_first", 16'(SCPU_LATCH_DO), 16'h20);
    SCPU_MREQ = 1'b0; SCPU_RD = 1'b0; SCPUAD = 16'h0000;
    SNDRQ = 1'b1; SNDNO = 8'h24;
    tick();
    SNDRQ = 1'b0;
    tick();
    check("t4_overrun", 16'(OVERRUN), 16'h0);
    for (int i = 1; i <= 4; i++) begin
      read_byte(rv);
      check("t4_read", 16'(rv), 16'h20 + 16'(i));
    end
    check("t4_pending_0", 16'(PENDING), 16'h0);

    // periodic IRQ: hold timeout, period, acknowledge
    guard = 0;
    while (!SCPU_INT && guard < 2000) begin tick(); guard++; end
    check("t5_rise_timeout", 16'(guard < 2000), 16'h1);
    cyc = 0;
    while (SCPU_INT && cyc < 2000) begin tick(); cyc++; end
    check("t5_hold_cycles", 16'(cyc), 16'(IRQ_HOLD * EN_DIV));
    while (!SCPU_INT && cyc < 2000) begin tick(); cyc++; end
    check("t5_period_cycles", 16'(cyc), 16'(IRQ_PERIOD * EN_DIV));
    check("t5_int_high", 16'(SCPU_INT), 16'h1);
    SCPU_M1 = 1'b1; SCPU_IORQ = 1'b1;
    tick();
    SCPU_M1 = 1'b0; SCPU_IORQ = 1'b0;
    check("t5_ack_clear", 16'(SCPU_INT), 16'h0);

    // asynchronous reset in the middle of an NMI with two queued entries
    do_reset();
    push_byte(8'hA1);
    push_byte(8'hA2);
    tick();
    tick();
    check("t6_nmi_pre",     16'(SCPU_NMI), 16'h1);
    check("t6_pending_pre", 16'(PENDING),  16'h1);
    RESET_N = 1'b0;
    #2;
    check("t6_nmi",     16'(SCPU_NMI),      16'h0);
    check("t6_pending", 16'(PENDING),       16'h0);
    check("t6_latch",   16'(SCPU_LATCH_DO), 16'h00);
    tick();
    RESET_N = 1'b1;
    tick();

    // randomized traffic, first with rare reads to exercise overflow
    for (int c = 0; c < 3000; c++) begin
      SNDRQ     = ($urandom_range(0, 3) == 0);
      SNDNO     = 8'($urandom);
      SCPUAD    = ($urandom_range(0, 1) == 1) ? {4'hE, 12'($urandom)} : 16'($urandom);
      SCPU_MREQ = (c < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      SCPU_RD   = ($urandom_range(0, 3) != 0);
      SCPU_M1   = ($urandom_range(0, 31) == 0);
      SCPU_IORQ = SCPU_M1 || ($urandom_range(0, 7) == 0);
      if (c == 2000) begin
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
      end
      tick();
    end
    SNDRQ = 1'b0; SCPU_MREQ = 1'b0; SCPU_RD = 1'b0; SCPU_M1 = 1'b0; SCPU_IORQ = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
